// File: rtl/tensor_mac_pkg.sv
// Shared types and arithmetic helpers for the tensor MAC engine.
package tensor_mac_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_DONE
    } state_t;

    // Sized so DEPTH full-scale products can never overflow the accumulator.
    function automatic int unsigned acc_width(int unsigned data_w, int unsigned depth);
        return 2 * data_w + $clog2(depth);
    endfunction

    // Arithmetic shift, optional ReLU, then clamp to a data_w-bit signed range.
    function automatic logic signed [31:0] sat_relu(logic signed [63:0] acc,
                                                    int unsigned shift,
                                                    logic relu_en,
                                                    int unsigned data_w);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = acc >>> shift;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (relu_en && (v < 64'sd0)) begin
            v = 64'sd0;
        end
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        return 32'(v);
    endfunction

endpackage

// File: rtl/tensor_mac_engine_if.sv
// Strobe, data and status bundle of the tensor MAC engine.
interface tensor_mac_engine_if #(
    parameter int unsigned DATA_W = 8
);
    logic signed [DATA_W-1:0] din;
    logic                     wr_en;
    logic                     acc_en;
    logic                     rd_en;
    logic                     clear;
    logic                     relu_en;
    logic signed [DATA_W-1:0] dout;
    logic                     dout_valid;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output din, wr_en, acc_en, rd_en, clear, relu_en,
        input  dout, dout_valid, busy, done, err
    );

    modport slave (
        input  din, wr_en, acc_en, rd_en, clear, relu_en,
        output dout, dout_valid, busy, done, err
    );
endinterface

// File: rtl/tensor_mac_post.sv
// Combinational post-processing: arithmetic shift, optional ReLU, saturation.
module tensor_mac_post
    import tensor_mac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 19,
    parameter int unsigned SHIFT  = 4
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     relu_en,
    output logic signed [DATA_W-1:0] res
);

    always_comb begin
        res = DATA_W'(sat_relu(64'(acc), SHIFT, relu_en, DATA_W));
    end

endmodule

// File: rtl/tensor_mac_engine.sv
// Signed MAC engine: weight buffer, dot-product sequencer and post-processed readout.
module tensor_mac_engine
    import tensor_mac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SHIFT  = 4
) (
    input logic clk,
    input logic rst_n,
    tensor_mac_engine_if.slave bus
);

    localparam int unsigned ACC_W = acc_width(DATA_W, DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned EXT_W = ACC_W - 2 * DATA_W;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    state_t                   state;
    logic signed [DATA_W-1:0] w [DEPTH];
    logic [PTR_W-1:0]         wptr;
    logic [PTR_W-1:0]         mptr;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] dout_q;
    logic                     valid_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;

    logic signed [2*DATA_W-1:0] din_ext;
    logic signed [2*DATA_W-1:0] w_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [PTR_W-1:0]           wptr_next;
    logic signed [DATA_W-1:0]   post_res;

    // mptr is zero whenever the FSM sits in S_LOAD, so w[mptr] is w[0] for the first term.
    always_comb begin
        din_ext   = {{DATA_W{bus.din[DATA_W-1]}}, bus.din};
        w_ext     = {{DATA_W{w[mptr][DATA_W-1]}}, w[mptr]};
        prod      = din_ext * w_ext;
        prod_ext  = {{EXT_W{prod[2*DATA_W-1]}}, prod};
        wptr_next = (wptr == LAST) ? '0 : wptr + PTR_W'(1);
    end

    tensor_mac_post #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) u_post (
        .acc     (acc),
        .relu_en (bus.relu_en),
        .res     (post_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOAD;
            for (int i = 0; i < int'(DEPTH); i++) begin
                w[i] <= '0;
            end
            wptr    <= '0;
            mptr    <= '0;
            acc     <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.clear) begin
            state   <= S_LOAD;
            acc     <= '0;
            wptr    <= '0;
            mptr    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (bus.wr_en) begin
                        w[wptr] <= bus.din;
                        wptr    <= wptr_next;
                        if (bus.acc_en) begin
                            err_q <= 1'b1;
                        end
                    end else if (bus.acc_en) begin
                        acc    <= prod_ext;
                        mptr   <= PTR_W'(1);
                        state  <= S_MAC;
                        busy_q <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (bus.wr_en) begin
                        err_q <= 1'b1;
                    end
                    if (bus.acc_en) begin
                        acc <= acc + prod_ext;
                        if (mptr == LAST) begin
                            mptr   <= '0;
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            mptr <= mptr + PTR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (bus.acc_en) begin
                        err_q <= 1'b1;
                    end
                    if (bus.rd_en) begin
                        dout_q  <= post_res;
                        valid_q <= 1'b1;
                        acc     <= '0;
                        wptr    <= '0;
                        state   <= S_LOAD;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_LOAD;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
